seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Downstream consumer of the stopwatch's packed 4-bit BCD digits.
- Time-multiplexes four BCD digits onto a common-anode 4-digit seven-segment display: one digit lit per scan slot, segments decoded per digit.
- Inputs are captured once per frame so a frame never mixes old and new time values.
- Optional leading-zero blanking; invalid codes render as a dash.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (>=1); 100 MHz clk gives a 2 kHz digit rate and a 500 Hz frame rate.
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = always show all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 = all digits dark, scan frozen
- digits  in  16  four BCD digits; [3:0] = digit0 (rightmost) .. [15:12] = digit3 (leftmost)
- dp  in  4  decimal point request per digit, bit i = digit i
- an  out  4  anode selects, active-low, bit i = digit i
- seg  out  7  segments, active-low, bit0=a .. bit6=g
- dp_n  out  1  decimal point segment, active-low
- frame_start  out  1  one-cycle pulse when a new shadow frame is captured

Behaviour:
- Reset (rst=1 at a clk edge): div_cnt=0, idx=0, shadow digits=0, shadow dp=0, primed=0; an=4'b1111, seg=7'h7F, dp_n=1, frame_start=0.
- Prescaler, while en=1:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick = (div_cnt==SCAN_DIV-1).
  - On tick, idx <= idx+1 mod 4.
  - SCAN_DIV=1 gives tick every cycle.
- Shadow capture: digits/dp load into the shadow registers when en=1 and either:
  - primed=0 (first enabled cycle after reset; sets primed=1), or
  - tick with idx==3 (wrap to 0).
- frame_start is registered: it is 1 in the cycle after a capture, else 0.
- Outputs are registered from idx and shadow; 1 clk latency from an idx change to an/seg change.
  - an = ~(1<<idx).
  - seg = decode(shadow digit[idx]).
  - dp_n = ~shadow_dp[idx].
- Decode, active-low, digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- Decode, codes 10..15: dash (g only), seg=7'h3F.
- Leading-zero blanking (BLANK_LZ=1):
  - digit k (k=3,2,1) is blanked when shadow digits k..3 are all 0 and shadow_dp[k]=0.
  - Blanked means an bit stays 1, seg=7'h7F, dp_n=1; the slot still consumes its time.
  - Digit0 is never blanked.
- en=0:
  - div_cnt, idx, shadow and primed hold.
  - Next cycle an=4'b1111, seg=7'h7F, dp_n=1; frame_start=0.
  - When en returns to 1, scanning resumes from the held div_cnt/idx.
- Input changes mid-frame have no visible effect until the next capture.
- Reset mid-frame: all state and outputs return to reset values at the next edge; no partial-frame residue.

Decomposition:
- Shared package seg7_pkg:
  - SEG_OFF=7'h7F, SEG_DASH=7'h3F, AN_OFF=4'hF.
  - 10-entry active-low digit pattern constant.
  - Digit-index typedef (2 bits).
- One natural sub-module: bcd_to_seg7 (combinational, 4-bit code in, 7-bit active-low pattern out, dash for 10..15).
- Prescaler, scan counter, shadow and blanking logic stay in seg7_scan.

Test Plan:
- SCAN_DIV=4, BLANK_LZ=0, en=1, digits=16'h1234, dp=0 after reset -> frame_start pulses once; an cycles 1110,1101,1011,0111 with 4-cycle slots; seg cycles 19,30,24,79; dp_n=1 throughout.
- digits=16'h0005, BLANK_LZ=1 -> digit0 slot seg=12 with an=1110; slots 1..3 keep an=1111, seg=7F; dp=4'b0100 makes digit2 show 40 with dp_n=0, while digits 3 and 1 stay blanked.
- digits=16'hFA09 -> digit0 seg=10, digit1 seg=40, digits 2 and 3 seg=3F (dash), none blanked.
- Change digits from 16'h1111 to 16'h2222 while idx=1 -> slots 2 and 3 still show 79; 24 first appears in the slot after the next frame_start.
- Deassert en for 10 cycles mid-slot -> an=1111 from the next cycle; on re-enable the same idx resumes and completes the remaining slot count; no frame_start during the pause.
- SCAN_DIV=1, then rst=1 while idx=2 -> idx advances every cycle before reset; the cycle after rst, an=1111, seg=7F, frame_start=0; the first enabled cycle afterwards recaptures the inputs.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scanner
package seg7_pkg;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [3:0] AN_OFF   = 4'hF;

   // active-low a..g patterns, entry i is the glyph for BCD digit i
   localparam logic [9:0][6:0] DIGIT_PAT = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// rtl/seg7_scan_bcd_to_seg7.sv - combinational BCD to active-low segment decoder
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (code <= 4'd9)
         seg = DIGIT_PAT[code];
   end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed seven-segment scanner with frame-coherent shadow capture
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        frame_start
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div_cnt;
   digit_idx_t    idx;
   logic [15:0]   sh_digits;
   logic [3:0]    sh_dp;
   logic          primed;

   logic          tick;
   logic          capture;
   logic [3:0]    cur_code;
   logic [6:0]    cur_pat;
   logic [3:0]    zero_up;
   logic          cur_blank;

   assign tick     = (div_cnt == DIV_MAX);
   assign capture  = en & (~primed | (tick & (idx == 2'd3)));
   assign cur_code = sh_digits[{idx, 2'b00} +: 4];

   // zero_up[k]: shadow digits k..3 are all zero; digit0 is never a blank candidate
   always_comb begin
      zero_up    = 4'b0000;
      zero_up[3] = (sh_digits[15:12] == 4'd0);
      zero_up[2] = zero_up[3] & (sh_digits[11:8] == 4'd0);
      zero_up[1] = zero_up[2] & (sh_digits[7:4] == 4'd0);
      cur_blank  = (BLANK_LZ != 0) && zero_up[idx] && !sh_dp[idx];
   end

   bcd_to_seg7 u_dec (
      .code (cur_code),
      .seg  (cur_pat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         idx         <= 2'd0;
         sh_digits   <= 16'h0000;
         sh_dp       <= 4'h0;
         primed      <= 1'b0;
         an          <= AN_OFF;
         seg         <= SEG_OFF;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= capture;
         if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick)
               idx <= idx + 2'd1;
            if (capture) begin
               sh_digits <= digits;
               sh_dp     <= dp;
               primed    <= 1'b1;
            end
            // a blanked slot still occupies its full time, it is just dark
            if (cur_blank) begin
               an   <= AN_OFF;
               seg  <= SEG_OFF;
               dp_n <= 1'b1;
            end else begin
               an   <= ~(4'b0001 << idx);
               seg  <= cur_pat;
               dp_n <= ~sh_dp[idx];
            end
         end else begin
            an   <= AN_OFF;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan
module tb_seg7_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp = 4'h0;

   logic [3:0] an0, an1, an2;
   logic [6:0] seg0, seg1, seg2;
   logic       dpn0, dpn1, dpn2;
   logic       fs0, fs1, fs2;

   int sel = 0;
   logic [3:0] o_an;
   logic [6:0] o_seg;
   logic       o_dpn;
   logic       o_fs;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seg7_scan #(.SCAN_DIV(4), .BLANK_LZ(0)) u0 (
      .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp),
      .an(an0), .seg(seg0), .dp_n(dpn0), .frame_start(fs0));

   seg7_scan #(.SCAN_DIV(4), .BLANK_LZ(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp),
      .an(an1), .seg(seg1), .dp_n(dpn1), .frame_start(fs1));

   seg7_scan #(.SCAN_DIV(1), .BLANK_LZ(1)) u2 (
      .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp),
      .an(an2), .seg(seg2), .dp_n(dpn2), .frame_start(fs2));

   always_comb begin
      o_an = an0; o_seg = seg0; o_dpn = dpn0; o_fs = fs0;
      if (sel == 1) begin
         o_an = an1; o_seg = seg1; o_dpn = dpn1; o_fs = fs1;
      end else if (sel == 2) begin
         o_an = an2; o_seg = seg2; o_dpn = dpn2; o_fs = fs2;
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic f);
      chk({tag, ".an"},  {12'h0, o_an},  {12'h0, a});
      chk({tag, ".seg"}, {9'h0, o_seg},  {9'h0, s});
      chk({tag, ".dpn"}, {15'h0, o_dpn}, {15'h0, d});
      chk({tag, ".fs"},  {15'h0, o_fs},  {15'h0, f});
   endtask

   // after edge P_n the outputs show slot (n/4)%4; a new frame is captured at P15
   task automatic run_chk(input string tag, input int n_first, input int n_last,
                          input logic [3:0][3:0] ans, input logic [3:0][6:0] segs,
                          input logic [3:0] dpns);
      int s;
      for (int n = n_first; n <= n_last; n++) begin
         step();
         s = (n / 4) % 4;
         chk_out($sformatf("%s.n%0d", tag, n), ans[s], segs[s], dpns[s], (n % 16) == 15);
      end
   endtask

   localparam logic [3:0][3:0] AN_STD = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   initial begin
      // reset state
      sel = 0;
      do_reset();
      chk_out("rst", 4'b1111, 7'h7F, 1'b1, 1'b0);

      // basic scan, no blanking
      digits = 16'h1234; dp = 4'h0; en = 1'b1;
      step();
      chk("t1.fs0", {15'h0, o_fs}, 16'h0001);
      run_chk("t1", 1, 16, AN_STD, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);

      // leading-zero blanking
      sel = 1;
      do_reset();
      digits = 16'h0005; dp = 4'h0; en = 1'b1;
      step();
      run_chk("t2a", 1, 15, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
              {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111);
      do_reset();
      dp = 4'b0100; en = 1'b1;
      step();
      run_chk("t2b", 1, 15, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
              {7'h7F, 7'h40, 7'h7F, 7'h12}, 4'b1011);

      // dashes for invalid codes, interior zero not blanked
      do_reset();
      digits = 16'hFA09; dp = 4'h0; en = 1'b1;
      step();
      run_chk("t3", 1, 15, AN_STD, {7'h3F, 7'h3F, 7'h40, 7'h10}, 4'b1111);

      // mid-frame input change waits for the next capture
      sel = 0;
      do_reset();
      digits = 16'h1111; en = 1'b1;
      step();
      run_chk("t4a", 1, 5, AN_STD, {4{7'h79}}, 4'b1111);
      digits = 16'h2222;
      run_chk("t4b", 6, 15, AN_STD, {4{7'h79}}, 4'b1111);
      run_chk("t4c", 16, 19, AN_STD, {4{7'h24}}, 4'b1111);

      // enable pause mid-slot, then resume same slot
      do_reset();
      digits = 16'h1234; en = 1'b1;
      step();
      run_chk("t5a", 1, 5, AN_STD, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out($sformatf("t5.off%0d", i), 4'b1111, 7'h7F, 1'b1, 1'b0);
      end
      en = 1'b1;
      step();
      chk_out("t5.r0", 4'b1101, 7'h30, 1'b1, 1'b0);
      step();
      chk_out("t5.r1", 4'b1101, 7'h30, 1'b1, 1'b0);
      step();
      chk_out("t5.r2", 4'b1011, 7'h24, 1'b1, 1'b0);

      // SCAN_DIV=1 scanning and reset mid-frame
      sel = 2;
      do_reset();
      digits = 16'h1234; dp = 4'h0; en = 1'b1;
      step();
      chk_out("t6.p0", 4'b1110, 7'h40, 1'b1, 1'b1);
      step();
      chk_out("t6.p1", 4'b1101, 7'h30, 1'b1, 1'b0);
      rst = 1'b1;
      digits = 16'h5678;
      step();
      chk_out("t6.rst", 4'b1111, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
      step();
      chk_out("t6.p3", 4'b1110, 7'h40, 1'b1, 1'b1);
      step();
      chk_out("t6.p4", 4'b1101, 7'h78, 1'b1, 1'b0);
      step();
      chk_out("t6.p5", 4'b1011, 7'h02, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
